decode_ctrl_stage: RTL and testbench

Registered decode controller for the RV32I/M 5-stage pipeline: decodes the ID-stage instruction into ALU/writeback/immediate controls and registers them into the ID/EX boundary. Unlike the earlier purely combinational decoder, it drives fully specified outputs for every opcode and flags illegal instructions. It supports optional M extension, and sequences multi-cycle MUL/DIV occupancy of EX with a counter-based stall FSM. It sits between the IF/ID register and the EX stage; `stall_d` drives PC/IF-ID enables in the hazard logic.

---
 rtl/decode_ctrl_stage.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// ID-stage decoder for RV32I/M with a registered ID/EX control boundary and a
// counter-based stall FSM that holds EX while a multi-cycle MUL/DIV is running.
`timescale 1ns/1ps
module decode_ctrl_stage #(
  parameter bit EN_M       = 1'b1,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstD,
  input  logic        valid_d,
  input  logic        flush,
  input  logic        stall_ex,
  output logic        valid_e,
  output logic        illegal_e,
  output logic        reg_wr_e,
  output logic        mem_wr_e,
  output logic        branch_e,
  output logic        jump_e,
  output logic        sel_a_e,
  output logic        sel_b_e,
  output logic [1:0]  wb_sel_e,
  output logic [2:0]  imm_src_e,
  output logic [2:0]  funct3_e,
  output logic [4:0]  alu_op_e,
  output logic        md_busy,
  output logic        stall_d
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_SLL  = 5'b00010;
  localparam logic [4:0] ALU_SLT  = 5'b00011;
  localparam logic [4:0] ALU_SLTU = 5'b00100;
  localparam logic [4:0] ALU_XOR  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SRA  = 5'b00111;
  localparam logic [4:0] ALU_OR   = 5'b01000;
  localparam logic [4:0] ALU_AND  = 5'b01001;
  localparam logic [4:0] ALU_LUI  = 5'b01010;
  localparam logic [4:0] ALU_MUL  = 5'b01011;

  localparam logic [1:0] WB_PC4 = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Residual occupancy after the capture cycle; zero means no stall at all.
  localparam logic [6:0] MUL_LOAD = 7'(MUL_CYCLES - 1);
  localparam logic [6:0] DIV_LOAD = 7'(DIV_CYCLES - 1);

  typedef struct packed {
    logic       illegal;
    logic       reg_wr;
    logic       mem_wr;
    logic       branch;
    logic       jump;
    logic       sel_a;
    logic       sel_b;
    logic [1:0] wb_sel;
    logic [2:0] imm_src;
    logic [2:0] funct3;
    logic [4:0] alu_op;
  } ctrl_t;

  typedef enum logic {IDLE = 1'b0, MD_WAIT = 1'b1} state_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  logic [4:0] base_op;
  logic [4:0] m_op;

  ctrl_t      dec_ctrl;
  logic       dec_legal;
  logic       dec_is_m;

  ctrl_t      cap_ctrl;
  logic       cap_valid;
  logic       cap_md;
  logic [6:0] cap_load;
  logic       capture;

  ctrl_t      ctrl_reg;
  logic       valid_reg;

  state_t     state_reg, state_next;
  logic [6:0] cnt_reg, cnt_next;

  assign opcode = InstD[6:0];
  assign funct3 = InstD[14:12];
  assign funct7 = InstD[31:25];
  // Register specifiers and immediates are consumed by the datapath, not here.
  assign unused_fields = ^{InstD[24:15], InstD[11:7]};

  always_comb begin : base_alu
    base_op = ALU_ADD;
    case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
    // MUL..REMU occupy consecutive codes in funct3 order.
    m_op = ALU_MUL + {2'b00, funct3};
  end

  always_comb begin : decode
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    dec_is_m  = 1'b0;
    case (opcode)
      OPC_R: begin
        dec_ctrl.reg_wr = 1'b1;
        dec_ctrl.sel_a  = 1'b1;
        dec_ctrl.wb_sel = WB_ALU;
        dec_ctrl.funct3 = funct3;
        case (funct7)
          F7_BASE: dec_ctrl.alu_op = base_op;
          F7_ALT: begin
            if (funct3 == 3'b000)      dec_ctrl.alu_op = ALU_SUB;
            else if (funct3 == 3'b101) dec_ctrl.alu_op = ALU_SRA;
            else                       dec_legal = 1'b0;
          end
          F7_MULDIV: begin
            if (EN_M) begin
              dec_ctrl.alu_op = m_op;
              dec_is_m        = 1'b1;
            end else begin
              dec_legal = 1'b0;
            end
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_IMM: begin
        dec_ctrl.reg_wr  = 1'b1;
        dec_ctrl.sel_a   = 1'b1;
        dec_ctrl.sel_b   = 1'b1;
        dec_ctrl.wb_sel  = WB_ALU;
        dec_ctrl.imm_src = IMM_I;
        dec_ctrl.funct3  = funct3;
        dec_ctrl.alu_op  = base_op;
        // Shift-immediates reuse funct7 as an opcode extension, so it must be exact.
        if (funct3 == 3'b001 && funct7 != F7_BASE)
          dec_legal = 1'b0;
        if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT)
          dec_legal = 1'b0;
      end
      OPC_LOAD: begin
        dec_ctrl.reg_wr  = 1'b1;
        dec_ctrl.sel_a   = 1'b1;
        dec_ctrl.sel_b   = 1'b1;
        dec_ctrl.wb_sel  = WB_MEM;
        dec_ctrl.imm_src = IMM_I;
        dec_ctrl.funct3  = funct3;
      end
      OPC_STORE: begin
        dec_ctrl.mem_wr  = 1'b1;
        dec_ctrl.sel_a   = 1'b1;
        dec_ctrl.sel_b   = 1'b1;
        dec_ctrl.imm_src = IMM_S;
        dec_ctrl.funct3  = funct3;
      end
      OPC_LUI: begin
        dec_ctrl.reg_wr  = 1'b1;
        dec_ctrl.sel_b   = 1'b1;
        dec_ctrl.wb_sel  = WB_ALU;
        dec_ctrl.imm_src = IMM_U;
        dec_ctrl.alu_op  = ALU_LUI;
      end
      OPC_AUIPC: begin
        dec_ctrl.reg_wr  = 1'b1;
        dec_ctrl.sel_b   = 1'b1;
        dec_ctrl.wb_sel  = WB_ALU;
        dec_ctrl.imm_src = IMM_U;
      end
      OPC_BRANCH: begin
        // ALU forms the target PC+imm; the compare is selected by funct3 in EX.
        dec_ctrl.branch  = 1'b1;
        dec_ctrl.sel_b   = 1'b1;
        dec_ctrl.imm_src = IMM_B;
        dec_ctrl.funct3  = funct3;
      end
      OPC_JAL: begin
        dec_ctrl.jump    = 1'b1;
        dec_ctrl.reg_wr  = 1'b1;
        dec_ctrl.sel_b   = 1'b1;
        dec_ctrl.wb_sel  = WB_PC4;
        dec_ctrl.imm_src = IMM_J;
      end
      OPC_JALR: begin
        dec_ctrl.jump    = 1'b1;
        dec_ctrl.reg_wr  = 1'b1;
        dec_ctrl.sel_a   = 1'b1;
        dec_ctrl.sel_b   = 1'b1;
        dec_ctrl.wb_sel  = WB_PC4;
        dec_ctrl.imm_src = IMM_I;
        dec_ctrl.funct3  = funct3;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin : capture_sel
    cap_ctrl  = '0;
    cap_valid = 1'b0;
    cap_md    = 1'b0;
    cap_load  = '0;
    if (valid_d) begin
      cap_valid = 1'b1;
      if (dec_legal) begin
        cap_ctrl = dec_ctrl;
        cap_md   = dec_is_m;
        cap_load = funct3[2] ? DIV_LOAD : MUL_LOAD;
      end else begin
        cap_ctrl.illegal = 1'b1;
      end
    end
  end

  assign capture = !flush && !stall_d;

  always_ff @(posedge clk or negedge rst_n) begin : fsm_state
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin : fsm_next
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (capture && cap_md) begin
            cnt_next   = cap_load;
            state_next = (cap_load != 7'd0) ? MD_WAIT : IDLE;
          end
        end
        MD_WAIT: begin
          // Counts down even under stall_ex: the unit keeps computing.
          cnt_next = cnt_reg - 7'd1;
          if (cnt_reg == 7'd1)
            state_next = IDLE;
        end
      endcase
    end
  end

  always_comb begin : fsm_out
    md_busy = (state_reg == MD_WAIT);
    stall_d = stall_ex | md_busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin : ex_register
    if (!rst_n) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
    end else if (!stall_d) begin
      valid_reg <= cap_valid;
      ctrl_reg  <= cap_ctrl;
    end
  end

  assign valid_e   = valid_reg;
  assign illegal_e = ctrl_reg.illegal;
  assign reg_wr_e  = ctrl_reg.reg_wr;
  assign mem_wr_e  = ctrl_reg.mem_wr;
  assign branch_e  = ctrl_reg.branch;
  assign jump_e    = ctrl_reg.jump;
  assign sel_a_e   = ctrl_reg.sel_a;
  assign sel_b_e   = ctrl_reg.sel_b;
  assign wb_sel_e  = ctrl_reg.wb_sel;
  assign imm_src_e = ctrl_reg.imm_src;
  assign funct3_e  = ctrl_reg.funct3;
  assign alu_op_e  = ctrl_reg.alu_op;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench for decode_ctrl_stage: a driver pushes predicted EX state per
// cycle from an instruction-level model; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_decode_ctrl_stage;

  localparam int MUL_N = 1;
  localparam int DIV_N = 32;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] SUB  = 32'h402081B3;
  localparam logic [31:0] DIV  = 32'h0220C1B3;
  localparam logic [31:0] MUL  = 32'h022081B3;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       reg_wr;
    logic       mem_wr;
    logic       branch;
    logic       jump;
    logic       sel_a;
    logic       sel_b;
    logic [1:0] wb;
    logic [2:0] imm;
    logic [2:0] f3;
    logic [4:0] alu;
    logic       busy;
  } ex_t;

  typedef struct { int cyc; logic st; } st_ent_t;
  typedef struct { int cyc; ex_t ex; } ex_ent_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] InstD = '0;
  logic valid_d = 1'b0, flush = 1'b0, stall_ex = 1'b0;
  logic valid_e, illegal_e, reg_wr_e, mem_wr_e, branch_e, jump_e, sel_a_e, sel_b_e;
  logic [1:0] wb_sel_e;
  logic [2:0] imm_src_e, funct3_e;
  logic [4:0] alu_op_e;
  logic md_busy, stall_d;

  logic [31:0] nm_inst = '0;
  logic nm_valid = 1'b0, nm_flush = 1'b0, nm_stall = 1'b0;
  logic nm_valid_e, nm_illegal_e, nm_reg_wr_e, nm_mem_wr_e, nm_branch_e, nm_jump_e;
  logic nm_sel_a_e, nm_sel_b_e, nm_md_busy, nm_stall_d;
  logic [1:0] nm_wb_sel_e;
  logic [2:0] nm_imm_src_e, nm_funct3_e;
  logic [4:0] nm_alu_op_e;

  int cycle = 0;
  int n_checks = 0;
  int n_pass = 0;
  ex_t ex_cur;
  int busy_left = 0;
  st_ent_t stall_q[$];
  ex_ent_t ex_q[$];
  st_ent_t mon_st;
  ex_ent_t mon_ex;
  ex_t got_ex;

  decode_ctrl_stage #(.EN_M(1'b1), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n), .InstD(InstD), .valid_d(valid_d), .flush(flush),
    .stall_ex(stall_ex), .valid_e(valid_e), .illegal_e(illegal_e), .reg_wr_e(reg_wr_e),
    .mem_wr_e(mem_wr_e), .branch_e(branch_e), .jump_e(jump_e), .sel_a_e(sel_a_e),
    .sel_b_e(sel_b_e), .wb_sel_e(wb_sel_e), .imm_src_e(imm_src_e), .funct3_e(funct3_e),
    .alu_op_e(alu_op_e), .md_busy(md_busy), .stall_d(stall_d)
  );

  decode_ctrl_stage #(.EN_M(1'b0), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut_nm (
    .clk(clk), .rst_n(rst_n), .InstD(nm_inst), .valid_d(nm_valid), .flush(nm_flush),
    .stall_ex(nm_stall), .valid_e(nm_valid_e), .illegal_e(nm_illegal_e),
    .reg_wr_e(nm_reg_wr_e), .mem_wr_e(nm_mem_wr_e), .branch_e(nm_branch_e),
    .jump_e(nm_jump_e), .sel_a_e(nm_sel_a_e), .sel_b_e(nm_sel_b_e),
    .wb_sel_e(nm_wb_sel_e), .imm_src_e(nm_imm_src_e), .funct3_e(nm_funct3_e),
    .alu_op_e(nm_alu_op_e), .md_busy(nm_md_busy), .stall_d(nm_stall_d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  assign got_ex = {valid_e, illegal_e, reg_wr_e, mem_wr_e, branch_e, jump_e, sel_a_e,
                   sel_b_e, wb_sel_e, imm_src_e, funct3_e, alu_op_e, md_busy};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cycle, got, exp);
  endtask

  // Instruction-level reference: what the pipeline should see in EX for this word.
  function automatic ex_t ref_decode(input logic [31:0] ins, input logic vld, input bit en_m);
    ex_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    bit ok;
    int base_tab[8];
    base_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    e = '0;
    ok = 1;
    opc = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    if (!vld) return e;
    case (opc)
      7'h33: begin
        e.reg_wr = 1; e.sel_a = 1; e.wb = 2'b01; e.f3 = f3;
        if (f7 == 7'h00) e.alu = 5'(base_tab[f3]);
        else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 5'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 5'd7;
        else if (f7 == 7'h01 && en_m) e.alu = 5'(11 + int'(f3));
        else ok = 0;
      end
      7'h13: begin
        e.reg_wr = 1; e.sel_a = 1; e.sel_b = 1; e.wb = 2'b01; e.f3 = f3;
        e.alu = 5'(base_tab[f3]);
        if (f3 == 3'd1 && f7 != 7'h00) ok = 0;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) e.alu = 5'd7;
          else if (f7 != 7'h00) ok = 0;
        end
      end
      7'h03: begin e.reg_wr = 1; e.sel_a = 1; e.sel_b = 1; e.wb = 2'b10; e.f3 = f3; end
      7'h23: begin e.mem_wr = 1; e.sel_a = 1; e.sel_b = 1; e.imm = 3'd1; e.f3 = f3; end
      7'h37: begin e.reg_wr = 1; e.sel_b = 1; e.wb = 2'b01; e.imm = 3'd4; e.alu = 5'd10; end
      7'h17: begin e.reg_wr = 1; e.sel_b = 1; e.wb = 2'b01; e.imm = 3'd4; end
      7'h63: begin e.branch = 1; e.sel_b = 1; e.imm = 3'd2; e.f3 = f3; end
      7'h6F: begin e.jump = 1; e.reg_wr = 1; e.sel_b = 1; e.imm = 3'd3; end
      7'h67: begin e.jump = 1; e.reg_wr = 1; e.sel_a = 1; e.sel_b = 1; e.f3 = f3; end
      default: ok = 0;
    endcase
    if (!ok) begin
      e = '0;
      e.illegal = 1;
    end
    e.valid = 1;
    return e;
  endfunction

  function automatic int occupancy(input ex_t e);
    if (e.valid && !e.illegal && e.alu >= 5'd11 && e.alu <= 5'd14) return MUL_N;
    if (e.valid && !e.illegal && e.alu >= 5'd15 && e.alu <= 5'd18) return DIV_N;
    return 1;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0] f7;
    int k;
    r = $urandom;
    k = $urandom_range(0, 13);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    case (k)
      0, 1:    return {f7, r[24:7], 7'h33};
      2, 3:    return {f7, r[24:7], 7'h13};
      4:       return {r[31:7], 7'h03};
      5:       return {r[31:7], 7'h23};
      6:       return {r[31:7], 7'h37};
      7:       return {r[31:7], 7'h17};
      8:       return {r[31:7], 7'h63};
      9:       return {r[31:7], 7'h6F};
      10:      return {r[31:7], 7'h67};
      11:      return {7'h01, r[24:7], 7'h33};
      default: return r;
    endcase
  endfunction

  // One clock of stimulus; predicts this cycle's stall_d and next cycle's EX.
  task automatic step(input logic [31:0] ins, input logic vld, input logic fl, input logic st);
    logic stall_exp;
    ex_t exp;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    InstD = ins;
    valid_d = vld;
    flush = fl;
    stall_ex = st;
    stall_exp = st || (busy_left > 0);
    stall_q.push_back('{cycle, stall_exp});
    if (fl) begin
      ex_cur = '0;
      busy_left = 0;
    end else if (stall_exp) begin
      if (busy_left > 0) busy_left--;
    end else begin
      ex_cur = ref_decode(ins, vld, 1'b1);
      busy_left = occupancy(ex_cur) - 1;
    end
    exp = ex_cur;
    exp.busy = (busy_left > 0);
    ex_q.push_back('{cycle + 1, exp});
  endtask

  task automatic reset_mid(input logic st);
    ex_t z;
    z = '0;
    @(posedge clk);
    #2;
    stall_ex = st;
    flush = 1'b0;
    valid_d = 1'b1;
    InstD = ADD;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ex", 32'(got_ex), 32'(z));
    chk("rst_mid_stall_d", 32'(stall_d), 32'(st));
    while (ex_q.size() > 0 && ex_q[$].cyc >= cycle) void'(ex_q.pop_back());
    ex_cur = '0;
    busy_left = 0;
    stall_q.push_back('{cycle, st});
    ex_q.push_back('{cycle, z});
    ex_q.push_back('{cycle + 1, z});
  endtask

  task automatic nm_case(input logic [31:0] ins, input logic exp_ill);
    nm_inst = ins;
    nm_valid = 1'b1;
    step(NOP, 1'b1, 1'b0, 1'b0);
    #1;
    chk("nm_valid_e", 32'(nm_valid_e), 32'(1'b1));
    chk("nm_illegal_e", 32'(nm_illegal_e), 32'(exp_ill));
    chk("nm_reg_wr_e", 32'(nm_reg_wr_e), 32'(!exp_ill));
    chk("nm_stall_d", 32'(nm_stall_d), 32'(1'b0));
  endtask

  always @(negedge clk) begin
    while (stall_q.size() > 0 && stall_q[0].cyc <= cycle) begin
      mon_st = stall_q.pop_front();
      chk("stall_d", 32'(stall_d), 32'(mon_st.st));
    end
    while (ex_q.size() > 0 && ex_q[0].cyc <= cycle) begin
      mon_ex = ex_q.pop_front();
      chk("ex_ctrl", 32'(got_ex), 32'(mon_ex.ex));
    end
  end

  initial begin
    ex_cur = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_ex", 32'(got_ex), 32'd0);
    chk("reset_stall_d", 32'(stall_d), 32'(stall_ex));

    step(ADD, 1, 0, 0);
    step(SUB, 1, 0, 0);
    step(DIV, 1, 0, 0);
    for (int i = 0; i < 34; i++) step(ADD, 1, 0, 0);
    step(MUL, 1, 0, 0);
    step(SUB, 1, 0, 0);
    step(DIV, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(ADD, 1, 0, 0);
    step(ADD, 1, 1, 1);
    step(ADD, 1, 0, 0);
    step(32'h0000007F, 1, 0, 0);
    step(32'h0220D093, 1, 0, 0);
    step(32'h0020A423, 1, 0, 0);
    step(32'h123452B7, 1, 0, 0);
    step(32'h00001317, 1, 0, 0);
    step(32'h00208463, 1, 0, 0);
    step(32'h010000EF, 1, 0, 0);
    step(32'h000100E7, 1, 0, 0);
    step(ADD, 0, 0, 0);
    for (int i = 0; i < 70; i++) step(DIV, 1, 0, (i % 7) == 3);
    nm_case(MUL, 1'b1);
    nm_case(ADD, 1'b0);
    nm_case(DIV, 1'b1);
    step(DIV, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(ADD, 1, 0, 0);
    reset_mid(1'b1);
    step(SUB, 1, 0, 0);
    step(ADD, 1, 0, 0);

    for (int i = 0; i < 3000; i++)
      step(rand_inst(), $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 6) == 0);

    step(NOP, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(ex_q.size() + stall_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
